// File: rtl/add_sub_arbiter_if.sv
// Bundle of the two request channels, the shared adder-subtractor link,
// the result channel and the completed-operation count.
interface add_sub_arbiter_if #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
);
    logic             req0_valid;
    logic [WIDTH-1:0] req0_a;
    logic [WIDTH-1:0] req0_b;
    logic             req0_sel;
    logic             req0_ready;

    logic             req1_valid;
    logic [WIDTH-1:0] req1_a;
    logic [WIDTH-1:0] req1_b;
    logic             req1_sel;
    logic             req1_ready;

    logic [WIDTH-1:0] au_a;
    logic [WIDTH-1:0] au_b;
    logic             au_select;
    logic [WIDTH-1:0] au_sum;
    logic             au_cout;

    logic             res_valid;
    logic             res_ready;
    logic             res_id;
    logic [WIDTH-1:0] res_sum;
    logic             res_cout;
    logic             res_ovf;
    logic [CNT_W-1:0] op_count;

    // Arbiter side
    modport slave (
        input  req0_valid, req0_a, req0_b, req0_sel,
        input  req1_valid, req1_a, req1_b, req1_sel,
        input  au_sum, au_cout, res_ready,
        output req0_ready, req1_ready,
        output au_a, au_b, au_select,
        output res_valid, res_id, res_sum, res_cout, res_ovf, op_count
    );

    // Requesters, shared unit and result consumer side
    modport master (
        output req0_valid, req0_a, req0_b, req0_sel,
        output req1_valid, req1_a, req1_b, req1_sel,
        output au_sum, au_cout, res_ready,
        input  req0_ready, req1_ready,
        input  au_a, au_b, au_select,
        input  res_valid, res_id, res_sum, res_cout, res_ovf, op_count
    );
endinterface

// File: rtl/add_sub_arbiter.sv
// Round-robin arbiter/sequencer time-sharing one combinational
// adder-subtractor between two requesters, with a held result channel.
module add_sub_arbiter #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input logic             clk,
    input logic             rst,
    add_sub_arbiter_if.slave bus
);
    localparam int MSB = WIDTH - 1;

    typedef enum logic [1:0] {IDLE, EXEC, HOLD} state_t;

    state_t           state;
    logic             last_grant;
    logic             id_q;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             op_sel;

    logic             accept_win;
    logic             gnt_id;
    logic             accept;
    logic             ovf_calc;

    assign bus.au_a      = op_a;
    assign bus.au_b      = op_b;
    assign bus.au_select = op_sel;

    // Grant selection and combinational ready; ready is held low during reset
    always_comb begin
        accept_win = (state == IDLE) || ((state == HOLD) && bus.res_ready);
        if (bus.req0_valid && bus.req1_valid)
            gnt_id = ~last_grant;
        else
            gnt_id = ~bus.req0_valid;
        bus.req0_ready = ~rst & accept_win & bus.req0_valid & ~gnt_id;
        bus.req1_ready = ~rst & accept_win & bus.req1_valid &  gnt_id;
        accept         = bus.req0_ready | bus.req1_ready;
    end

    // Signed overflow of the operation currently on the shared unit
    always_comb begin
        if (op_sel)
            ovf_calc = (op_a[MSB] != op_b[MSB]) && (bus.au_sum[MSB] != op_a[MSB]);
        else
            ovf_calc = (op_a[MSB] == op_b[MSB]) && (bus.au_sum[MSB] != op_a[MSB]);
    end

    // Sequencer: accept -> one execute cycle -> hold until consumed
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            last_grant   <= 1'b1;
            id_q         <= 1'b0;
            op_a         <= '0;
            op_b         <= '0;
            op_sel       <= 1'b0;
            bus.res_valid <= 1'b0;
            bus.res_id    <= 1'b0;
            bus.res_sum   <= '0;
            bus.res_cout  <= 1'b0;
            bus.res_ovf   <= 1'b0;
            bus.op_count  <= '0;
        end else begin
            case (state)
                EXEC: begin
                    bus.res_sum   <= bus.au_sum;
                    bus.res_cout  <= bus.au_cout;
                    bus.res_ovf   <= ovf_calc;
                    bus.res_id    <= id_q;
                    bus.res_valid <= 1'b1;
                    state         <= HOLD;
                end
                HOLD: begin
                    if (bus.res_ready) begin
                        bus.op_count  <= bus.op_count + CNT_W'(1);
                        bus.res_valid <= 1'b0;
                        state         <= IDLE;
                    end
                end
                default: ;
            endcase
            // Accept can only fire in IDLE or in a consumed HOLD, so it
            // overrides the IDLE transition taken above.
            if (accept) begin
                op_a       <= gnt_id ? bus.req1_a   : bus.req0_a;
                op_b       <= gnt_id ? bus.req1_b   : bus.req0_b;
                op_sel     <= gnt_id ? bus.req1_sel : bus.req0_sel;
                id_q       <= gnt_id;
                last_grant <= gnt_id;
                state      <= EXEC;
            end
        end
    end
endmodule

// File: doc/add_sub_arbiter.md
Name: add_sub_arbiter

Overview:
Round-robin arbiter and sequencer that time-shares one combinational WIDTH-bit adder-subtractor (A, B, Select in; Sum, Cout out) between two requesters. Each requester hands over operands and an operation through a valid/ready handshake. The block registers the operands, drives the shared unit, captures the result, and returns it through a held valid/ready response channel tagged with the requester ID. It sits between the two client datapaths and the single add_sub instance.

Parameters:
WIDTH, 4, operand/result width; must match the shared adder-subtractor.
CNT_W, 8, width of completed-operation counter.

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous active-high reset
req0_valid  input  1  requester 0 has an operation
req0_a  input  WIDTH  requester 0 operand A
req0_b  input  WIDTH  requester 0 operand B
req0_sel  input  1  requester 0 op: 0=add, 1=subtract
req0_ready  output  1  requester 0 operation accepted this cycle
req1_valid, req1_a, req1_b, req1_sel, req1_ready  same widths and directions as req0_*, for requester 1
au_a  output  WIDTH  to shared unit A
au_b  output  WIDTH  to shared unit B
au_select  output  1  to shared unit Select
au_sum  input  WIDTH  from shared unit Sum (combinational)
au_cout  input  1  from shared unit Cout
res_valid  output  1  result available
res_ready  input  1  consumer takes result
res_id  output  1  requester that issued the result
res_sum  output  WIDTH  result
res_cout  output  1  carry out (for subtract: 1 = no borrow)
res_ovf  output  1  two's-complement signed overflow
op_count  output  CNT_W  completed (delivered) operations

Behaviour:
- Reset: clk and rst are the only clock/reset. Reset is asynchronous and active-high. All outputs and registers clear to 0, state=IDLE, last_grant=1 (requester 0 wins the first tie). A reset mid-operation drops any in-flight or held result. Requesters keep valid asserted until they see ready.
- State IDLE: accepting. State EXEC: operand regs drive the unit. State HOLD: result held.
- Accept window: state IDLE, or state HOLD with res_ready=1.
- Grant in the accept window:
  - Only one requester valid: grant it.
  - Both valid: grant the requester not equal to last_grant.
- reqN_ready is combinational. It is 1 only for the granted requester in the accept window, and at most one ready is high per cycle.
- On accept:
  - Latch a, b, sel into op regs; latch the ID into id reg; update last_grant.
  - Next state: EXEC.
- au_a/au_b/au_select are driven directly from the op regs (registered, glitch-free). They keep their last value when not in EXEC.
- EXEC (exactly 1 cycle):
  - Capture res_sum=au_sum, res_cout=au_cout, res_id=id reg.
  - res_ovf: for add, (a[MSB]==b[MSB]) && (sum[MSB]!=a[MSB]); for sub, (a[MSB]!=b[MSB]) && (sum[MSB]!=a[MSB]).
  - Set res_valid=1. Next state: HOLD.
- HOLD:
  - res_valid and all res_* fields stay stable until res_ready=1.
  - On res_ready=1: op_count increments (wraps at 2^CNT_W−1 → 0). If a request is accepted that same cycle, go to EXEC with res_valid cleared next cycle; otherwise go to IDLE with res_valid cleared.
- Latency: accept cycle → res_valid high 2 edges later. Peak throughput: 1 op per 2 cycles under continuous res_ready.
- Requests arriving in EXEC, or in HOLD without res_ready, are not accepted (ready=0). The requester holds its valid.
- Changes to reqN_* while not granted are ignored. The block never samples a requester's data without asserting its ready.

Test Plan:
- Reset then req0 add a=1010 b=0101 with res_ready=1 → req0_ready 1 cycle; 2 edges later res_valid=1, res_id=0, res_sum=1111, res_cout=0, res_ovf=0, au_select=0; op_count=1.
- req1 sub a=1010 b=0101 → res_sum=0101, res_cout=1, res_ovf=1, res_id=1. Then req1 sub a=0101 b=1010 → res_sum=1011, res_cout=0, res_ovf=1.
- Both valid every cycle, res_ready=1: req0 add 1111+0001, req1 sub 0000−0001 → grants alternate 0,1,0,1. Results 0000/cout1 and 1111/cout0. Never both ready high in the same cycle.
- Backpressure: res_ready=0 for 5 cycles after res_valid with req0 valid (sub 1111−0001) → res fields stable, req0_ready=0 throughout. On res_ready=1, req0_ready=1 that cycle, next res_sum=1110, res_cout=1.
- Assert rst while in EXEC → all outputs 0 immediately (async). After release, a pending req1 is re-accepted first if req0 is idle, and op_count restarts at 0.
- Issue 256 completed ops with CNT_W=8 → op_count wraps to 0. Add 1110+0001 → 1111, res_cout=0.
